// File: rtl/reg_file.sv
// ============================================================================
// reg_file -- 32x32 MIPS register file: two combinational read ports, one
//             clocked write port, write-to-read bypass, register 0 fixed at 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r3_wr,
  input  logic [ADDR_W-1:0] r3_addr,
  input  logic [DATA_W-1:0] r3_din,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic [DATA_W-1:0] r1_dout,
  output logic [DATA_W-1:0] r2_dout
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic              w_wr_act;

  // A write is live only out of reset and away from the hardwired zero register;
  // the same qualifier gates both the storage update and the bypass.
  assign w_wr_act = rst_n && r3_wr && (r3_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_act) begin
      r_mem[r3_addr] <= r3_din;
    end
  end

  always_comb begin
    r1_dout = r_mem[r1_addr];
    if (r1_addr == '0) begin
      r1_dout = '0;
    end else if (w_wr_act && (r3_addr == r1_addr)) begin
      r1_dout = r3_din;
    end
  end

  always_comb begin
    r2_dout = r_mem[r2_addr];
    if (r2_addr == '0) begin
      r2_dout = '0;
    end else if (w_wr_act && (r3_addr == r2_addr)) begin
      r2_dout = r3_din;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file -- directed plus randomized checks of reg_file against an
//                array-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        r3_wr;
  logic [4:0]  r3_addr;
  logic [31:0] r3_din;
  logic [4:0]  r1_addr;
  logic [4:0]  r2_addr;
  logic [31:0] r1_dout;
  logic [31:0] r2_dout;

  logic [31:0] model [32];
  int          checks;
  int          errors;

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .r3_wr   (r3_wr),
    .r3_addr (r3_addr),
    .r3_din  (r3_din),
    .r1_addr (r1_addr),
    .r2_addr (r2_addr),
    .r1_dout (r1_dout),
    .r2_dout (r2_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a read port must show for the current inputs and stored contents.
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (rst_n && r3_wr && (r3_addr == a)) return r3_din;
    return model[a];
  endfunction

  // Apply the current inputs to the model, then let the DUT see the same edge.
  task automatic tick();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (r3_wr && (r3_addr != 5'd0)) begin
      model[r3_addr] = r3_din;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check both ports against fixed values and against the model.
  task automatic chk2(input string tag, input logic [31:0] e1, input logic [31:0] e2);
    #1;
    chk({tag, "_r1"}, r1_dout, e1);
    chk({tag, "_r2"}, r2_dout, e2);
    chk({tag, "_m1"}, r1_dout, expect_rd(r1_addr));
    chk({tag, "_m2"}, r2_dout, expect_rd(r2_addr));
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    r3_wr = 1'b1; r3_addr = a; r3_din = d;
    tick();
    r3_wr = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b0; r3_wr = 1'b0; r3_addr = '0; r3_din = '0; r1_addr = '0; r2_addr = '0;
    tick();
    rst_n = 1'b1;
    r1_addr = 5'd1; r2_addr = 5'd31;
    chk2("reset_state", 32'h0, 32'h0);

    // Reset drops a simultaneous write; outputs show storage while in reset
    wr(5'd5, 32'h1234_5678);
    rst_n = 1'b0; r3_wr = 1'b1; r3_addr = 5'd6; r3_din = 32'hFFFF_FFFF;
    r1_addr = 5'd5; r2_addr = 5'd6;
    chk2("in_reset", 32'h1234_5678, 32'h0);
    tick();
    rst_n = 1'b1; r3_wr = 1'b0;
    chk2("after_reset", 32'h0, 32'h0);

    wr(5'd8, 32'hDEAD_BEEF);
    wr(5'd31, 32'h0000_0001);
    r1_addr = 5'd8; r2_addr = 5'd31;
    chk2("basic_rw", 32'hDEAD_BEEF, 32'h0000_0001);

    r3_wr = 1'b1; r3_addr = 5'd0; r3_din = 32'hAAAA_AAAA; r1_addr = 5'd0; r2_addr = 5'd0;
    chk2("zero_bypass", 32'h0, 32'h0);
    tick();
    r3_wr = 1'b0;
    chk2("zero_after", 32'h0, 32'h0);

    wr(5'd5, 32'h11);
    r3_wr = 1'b1; r3_addr = 5'd5; r3_din = 32'h22; r1_addr = 5'd5; r2_addr = 5'd5;
    chk2("bypass_both", 32'h22, 32'h22);
    tick();
    r3_wr = 1'b0;
    chk2("bypass_after", 32'h22, 32'h22);

    wr(5'd9, 32'h33);
    r3_wr = 1'b1; r3_addr = 5'd7; r3_din = 32'h99; r1_addr = 5'd7; r2_addr = 5'd9;
    chk2("bypass_iso", 32'h99, 32'h33);
    tick();
    r3_wr = 1'b0; r1_addr = 5'd9; r2_addr = 5'd7;
    chk2("bypass_iso_after", 32'h33, 32'h99);

    wr(5'd10, 32'h44);
    r3_wr = 1'b0; r3_addr = 5'd10; r3_din = 32'h55; r1_addr = 5'd10; r2_addr = 5'd10;
    chk2("we_low", 32'h44, 32'h44);
    tick();
    chk2("we_low_after", 32'h44, 32'h44);

    wr(5'd3, 32'hA);
    wr(5'd3, 32'hB);
    r1_addr = 5'd3; r2_addr = 5'd0;
    chk2("last_wins", 32'hB, 32'h0);

    // Randomized traffic, checked against the model only
    for (int n = 0; n < 400; n++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      r3_wr   = ($urandom_range(0, 2) != 0);
      r3_addr = 5'($urandom_range(0, 31));
      r3_din  = $urandom;
      r1_addr = ($urandom_range(0, 3) == 0) ? r3_addr : 5'($urandom_range(0, 31));
      r2_addr = ($urandom_range(0, 3) == 0) ? r3_addr : 5'($urandom_range(0, 31));
      #1;
      chk("rand_r1", r1_dout, expect_rd(r1_addr));
      chk("rand_r2", r2_dout, expect_rd(r2_addr));
      tick();
    end

    rst_n = 1'b1; r3_wr = 1'b0;
    for (int a = 0; a < 32; a++) begin
      r1_addr = 5'(a); r2_addr = 5'(31 - a);
      #1;
      chk("sweep_r1", r1_dout, expect_rd(r1_addr));
      chk("sweep_r2", r2_dout, expect_rd(r2_addr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
